// File: rtl/scpad_req_arbiter.sv
// scpad_req_arbiter: FE/BE scratchpad request arbiter with starvation guard, outstanding-request order FIFO and response routing
// Ports: clk, rst (async, active-high)
//   fe_req_valid/fe_req/fe_req_ready, be_req_valid/be_req/be_req_ready : requester handshakes
//   sel_req/sel_req_ready : registered request to datapath
//   sel_res : datapath response; fe_res/be_res : routed registered responses
//   order_err : sticky response-ordering error
package scpad_pkg;
  localparam int DW = 32;
  localparam int XW = 4;
  typedef enum logic {SRC_FE = 1'b0, SRC_BE = 1'b1} src_e;
  typedef struct packed {
    logic          write;
    logic [XW-1:0] xbar;
    logic [DW-1:0] wdata;
  } req_t;
  typedef struct packed {
    logic          valid;
    logic          write;
    logic [XW-1:0] xbar;
    logic [DW-1:0] wdata;
    src_e          src;
  } sel_req_t;
  typedef struct packed {
    logic          valid;
    logic          write;
    src_e          src;
    logic [DW-1:0] rdata;
  } sel_res_t;
  typedef struct packed {
    logic          valid;
    logic          write;
    logic [DW-1:0] rdata;
  } res_t;
endpackage

module scpad_req_arbiter
  import scpad_pkg::*;
#(
  parameter int STARVE_LIMIT    = 4,
  parameter int OUTSTANDING_MAX = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     fe_req_valid,
  input  req_t     fe_req,
  output logic     fe_req_ready,
  input  logic     be_req_valid,
  input  req_t     be_req,
  output logic     be_req_ready,
  output sel_req_t sel_req,
  input  logic     sel_req_ready,
  input  sel_res_t sel_res,
  output res_t     fe_res,
  output res_t     be_res,
  output logic     order_err
);
  localparam int PW = OUTSTANDING_MAX > 1 ? $clog2(OUTSTANDING_MAX) : 1;
  localparam int CW = $clog2(OUTSTANDING_MAX + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  src_e          r_fifo [OUTSTANDING_MAX];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_total;
  logic          w_pop, w_issue, w_free, w_starved, w_fe_win, w_load, w_mis;
  req_t          w_win;
  sel_req_t      w_sel_nxt;
  res_t          w_fe_nxt, w_be_nxt;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING_MAX - 1)) ? '0 : p + 1'b1;
  endfunction
  assign w_total   = {1'b0, r_cnt} + (CW+1)'(sel_req.valid);
  assign w_pop     = sel_res.valid & (r_cnt != '0);
  assign w_issue   = sel_req.valid & sel_req_ready;
  // A same-cycle response pop frees a slot, so it can admit a load even at the limit
  assign w_free    = (!sel_req.valid | sel_req_ready) &
                     ((w_total < (CW+1)'(OUTSTANDING_MAX)) | w_pop);
  assign w_starved = r_starve == SW'(STARVE_LIMIT);
  assign w_fe_win  = fe_req_valid & (!be_req_valid | w_starved);
  assign w_load    = w_free & (fe_req_valid | be_req_valid) & !rst;
  assign fe_req_ready = w_load & w_fe_win;
  assign be_req_ready = w_load & !w_fe_win;
  assign w_mis     = sel_res.valid & ((r_cnt == '0) | (sel_res.src != r_fifo[r_rp]));
  always_comb begin
    w_win     = w_fe_win ? fe_req : be_req;
    w_sel_nxt = w_load ? '{1'b1, w_win.write, w_win.xbar, w_win.wdata, w_fe_win ? SRC_FE : SRC_BE}
              : sel_req_ready ? '0 : sel_req;
    w_fe_nxt  = (sel_res.valid && sel_res.src == SRC_FE) ? '{1'b1, sel_res.write, sel_res.rdata} : '0;
    w_be_nxt  = (sel_res.valid && sel_res.src == SRC_BE) ? '{1'b1, sel_res.write, sel_res.rdata} : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_req   <= '0;
      fe_res    <= '0;
      be_res    <= '0;
      order_err <= 1'b0;
      r_starve  <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
    end else begin
      sel_req   <= w_sel_nxt;
      fe_res    <= w_fe_nxt;
      be_res    <= w_be_nxt;
      order_err <= order_err | w_mis;
      if (be_req_ready && fe_req_valid) r_starve <= w_starved ? r_starve : r_starve + 1'b1;
      else if (fe_req_ready || !fe_req_valid) r_starve <= '0;
      if (w_issue) r_wp <= nxt(r_wp);
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_issue) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_issue) r_fifo[r_wp] <= sel_req.src;
  end
endmodule

// File: tb/tb_scpad_req_arbiter.sv
// tb_scpad_req_arbiter: directed plus randomized check of scpad_req_arbiter against a queue-based reference model
module tb_scpad_req_arbiter;
  import scpad_pkg::*;
  localparam int SL = 4;
  localparam int OM = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic fe_v = 1'b0, be_v = 1'b0, srr = 1'b0;
  req_t fe_r = '0, be_r = '0;
  sel_res_t sres = '0;
  logic fe_rdy, be_rdy, oerr;
  sel_req_t sel;
  res_t fe_res, be_res;

  scpad_req_arbiter #(.STARVE_LIMIT(SL), .OUTSTANDING_MAX(OM)) dut (
    .clk(clk), .rst(rst),
    .fe_req_valid(fe_v), .fe_req(fe_r), .fe_req_ready(fe_rdy),
    .be_req_valid(be_v), .be_req(be_r), .be_req_ready(be_rdy),
    .sel_req(sel), .sel_req_ready(srr), .sel_res(sres),
    .fe_res(fe_res), .be_res(be_res), .order_err(oerr)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  sel_req_t m_sel;
  src_e m_q[$];
  int m_starve;
  res_t m_fe, m_be;
  logic m_err;
  logic last_fe_rdy, last_be_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_sel = '0;
    m_q.delete();
    m_starve = 0;
    m_fe = '0;
    m_be = '0;
    m_err = 1'b0;
  endtask

  task automatic eval(output logic load, output logic few);
    int total;
    logic pop, free;
    total = m_q.size() + int'(m_sel.valid);
    pop   = sres.valid && m_q.size() > 0;
    free  = (!m_sel.valid || srr) && (total < OM || pop);
    few   = fe_v && (!be_v || m_starve == SL);
    load  = !rst && free && (fe_v || be_v);
  endtask

  task automatic update(input logic load, input logic few);
    req_t w;
    logic issue;
    issue = m_sel.valid && srr;
    if (sres.valid) begin
      if (m_q.size() == 0 || m_q[0] != sres.src) m_err = 1'b1;
      if (m_q.size() > 0) void'(m_q.pop_front());
    end
    if (issue) m_q.push_back(m_sel.src);
    if (load && !few && fe_v) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
    else if ((load && few) || !fe_v) m_starve = 0;
    m_fe = (sres.valid && sres.src == SRC_FE) ? '{1'b1, sres.write, sres.rdata} : '0;
    m_be = (sres.valid && sres.src == SRC_BE) ? '{1'b1, sres.write, sres.rdata} : '0;
    w = few ? fe_r : be_r;
    if (load) m_sel = '{1'b1, w.write, w.xbar, w.wdata, few ? SRC_FE : SRC_BE};
    else if (srr) m_sel = '0;
  endtask

  task automatic cyc();
    logic load, few;
    #1;
    eval(load, few);
    last_fe_rdy = fe_rdy;
    last_be_rdy = be_rdy;
    chk("fe_ready", fe_rdy, load && few);
    chk("be_ready", be_rdy, load && !few);
    chk("sel_req", sel, m_sel);
    chk("fe_res", fe_res, m_fe);
    chk("be_res", be_res, m_be);
    chk("order_err", oerr, m_err);
    @(posedge clk);
    if (rst) m_reset();
    else update(load, few);
    #1;
  endtask

  task automatic rnd_req();
    fe_r = '{1'($urandom), 4'($urandom), $urandom};
    be_r = '{1'($urandom), 4'($urandom), $urandom};
  endtask

  task automatic auto_resp(input int pct);
    if (m_q.size() > 0 && $urandom_range(99) < pct) sres = '{1'b1, 1'($urandom), m_q[0], $urandom};
    else sres = '0;
  endtask

  task automatic drain();
    fe_v = 1'b0;
    be_v = 1'b0;
    srr  = 1'b1;
    for (int i = 0; i < 40 && (m_q.size() > 0 || m_sel.valid); i++) begin
      auto_resp(100);
      cyc();
    end
    sres = '0;
  endtask

  initial begin
    m_reset();
    fe_v = 1'b1;
    be_v = 1'b1;
    rnd_req();
    cyc();
    cyc();
    rst = 1'b0;
    srr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rnd_req();
      auto_resp(100);
      cyc();
      chk("grant_pattern", last_be_rdy, (i % 5) != 4);
    end
    drain();
    fe_v = 1'b1;
    fe_r = '{1'b1, 4'hF, 32'hA5A5_A5A5};
    cyc();
    fe_v = 1'b0;
    chk("fe_write_sel", sel, {1'b1, 1'b1, 4'hF, 32'hA5A5_A5A5, SRC_FE});
    cyc();
    sres = '{1'b1, 1'b0, SRC_FE, 32'h1234_5678};
    cyc();
    sres = '0;
    chk("fe_res_route", fe_res, {1'b1, 1'b0, 32'h1234_5678});
    chk("be_res_quiet", be_res.valid, 1'b0);
    cyc();
    srr  = 1'b0;
    fe_v = 1'b1;
    rnd_req();
    for (int i = 0; i < 6; i++) cyc();
    chk("stall_ready", last_fe_rdy, 1'b0);
    drain();
    srr  = 1'b1;
    be_v = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rnd_req();
      cyc();
    end
    chk("full_ready", last_be_rdy, 1'b0);
    auto_resp(100);
    cyc();
    chk("pop_admits", last_be_rdy, 1'b1);
    for (int i = 0; i < 20; i++) begin
      fe_v = 1'($urandom);
      be_v = 1'($urandom);
      rnd_req();
      auto_resp(50);
      cyc();
    end
    drain();
    fe_v = 1'b1;
    rnd_req();
    cyc();
    fe_v = 1'b0;
    cyc();
    sres = '{1'b1, 1'b1, SRC_BE, 32'hDEAD_BEEF};
    cyc();
    sres = '0;
    chk("misorder_err", oerr, 1'b1);
    chk("misorder_route", be_res, {1'b1, 1'b1, 32'hDEAD_BEEF});
    cyc();
    sres = '{1'b1, 1'b0, SRC_FE, 32'h0};
    cyc();
    sres = '0;
    cyc();
    chk("err_sticky", oerr, 1'b1);
    for (int i = 0; i < 300; i++) begin
      fe_v = 1'($urandom);
      be_v = 1'($urandom);
      srr  = ($urandom_range(3) != 0);
      rnd_req();
      auto_resp(60);
      if ($urandom_range(19) == 0) sres = '{1'b1, 1'($urandom), src_e'($urandom_range(1)), $urandom};
      cyc();
    end
    drain();
    srr  = 1'b1;
    be_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rnd_req();
      cyc();
    end
    srr = 1'b0;
    cyc();
    sres = '{1'b1, 1'b0, SRC_BE, 32'h5};
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sel_valid", sel.valid, 1'b0);
    chk("arst_fe_res", fe_res.valid, 1'b0);
    chk("arst_be_res", be_res.valid, 1'b0);
    chk("arst_err", oerr, 1'b0);
    chk("arst_ready", be_rdy, 1'b0);
    m_reset();
    sres = '0;
    @(posedge clk);
    #1;
    cyc();
    rst  = 1'b0;
    be_v = 1'b0;
    srr  = 1'b1;
    sres = '{1'b1, 1'b0, SRC_BE, 32'h77};
    cyc();
    sres = '0;
    chk("empty_resp_err", oerr, 1'b1);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/scpad_req_arbiter.md
SCPAD_REQ_ARBITER -- requirements
Module: scpad_req_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive FE losses before FE is forced to win.
REQ-002 Parameter OUTSTANDING_MAX, default 8, max requests in flight (held in output register or issued awaiting response).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fe_req_valid  input  1  frontend request present.
REQ-006 fe_req  input  req_t  frontend request; write, xbar, wdata used.
REQ-007 fe_req_ready  output  1  frontend request accepted this cycle when high with fe_req_valid.
REQ-008 be_req_valid, be_req, be_req_ready  in/in/out  1/req_t/1  backend equivalents of REQ-005..007.
REQ-009 sel_req  output  sel_req_t  registered request to scratchpad datapath; valid field is the valid.
REQ-010 sel_req_ready  input  1  datapath accepts sel_req this cycle.
REQ-011 sel_res  input  sel_res_t  datapath response; valid, write, src, rdata.
REQ-012 fe_res, be_res  output  res_t each  registered routed responses.
REQ-013 order_err  output  1  sticky response-ordering error flag.

Function
REQ-014 Arbitration: BE wins when both valid, unless starve_cnt == STARVE_LIMIT, then FE wins.
REQ-015 starve_cnt: +1 (saturating at STARVE_LIMIT) on a cycle BE is accepted while fe_req_valid high; cleared when FE accepted or fe_req_valid low.
REQ-016 Output register loads when (empty or sel_req_ready high) and total < OUTSTANDING_MAX, or sel_res.valid high with nonempty order FIFO (same-cycle pop frees a slot).
REQ-017 total = order-FIFO count + sel_req.valid.
REQ-018 Only the winning requester sees ready high; both readys low when load condition false.
REQ-019 Loaded sel_req: valid=1, write/xbar/wdata copied from winner, src=SRC_FE or SRC_BE.
REQ-020 sel_req held stable while valid and sel_req_ready low; clears when sel_req_ready high and no new load.
REQ-021 Request latency: accepted at edge N, visible on sel_req after edge N (one cycle).
REQ-022 Issue (sel_req.valid & sel_req_ready) pushes src into order FIFO, depth OUTSTANDING_MAX, circular pointers wrapping modulo depth.
REQ-023 sel_res.valid pops FIFO head when nonempty; push and pop same cycle allowed, count unchanged.
REQ-024 Response routed by sel_res.src to fe_res or be_res next cycle: valid=1, write, rdata copied; other output valid=0.
REQ-025 sel_res.valid with FIFO empty, or sel_res.src != head, sets order_err; response still routed by sel_res.src; no pop when empty.
REQ-026 order_err stays high until reset.
REQ-027 Response valid outputs high one cycle per sel_res.valid; no backpressure on response path.

Reset
REQ-028 During/after rst: sel_req.valid=0, fe_res.valid=0, be_res.valid=0, readys=0 while rst high, order_err=0, starve_cnt=0, FIFO empty, pointers 0.
REQ-029 Reset mid-operation discards held request and all in-flight tracking; responses arriving after reset with FIFO empty set order_err.
REQ-030 Non-valid payload fields of outputs reset to 0.

Verification
REQ-031 Both valid every cycle, sel_req_ready=1, STARVE_LIMIT=4 -> grant order BE,BE,BE,BE,FE repeating; starve_cnt returns 0 after FE grant.
REQ-032 Single FE write, wdata=0xA5A5 lanes -> sel_req.valid one cycle later with src=SRC_FE, write=1; sel_res src=FE rdata=X -> fe_res.valid next cycle, rdata=X, be_res.valid=0.
REQ-033 sel_req_ready=0 for 5 cycles with FE valid -> sel_req stable, fe_req_ready=0 after first load, no FIFO push.
REQ-034 Issue 8 requests, no responses -> readys low, total=8; one sel_res.valid -> load accepted same cycle; 20 mixed issues/responses -> pointer wrap correct, no order_err.
REQ-035 sel_res with src=BE while head=FE -> order_err=1 next cycle and held; routed to be_res; sel_res with FIFO empty -> order_err=1, no count underflow.
REQ-036 rst asserted with 3 in flight and sel_req valid -> all valids 0 asynchronously, total=0, order_err=0.
